vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Produces the raster scan that drives color_mapper and the VGA DAC: DrawX/DrawY, hs, vs, blank and pixel_clk, all derived from the 50 MHz system clock.
- color_mapper consumes these and returns RGB; this block is the source end of that pixel interface.
- Also emits a one-cycle frame_start pulse for game logic (sprite position update once per frame).
- sync outputs are delayed by a configurable number of pixel ticks so that they line up with RGB after the ROM read and RGB register latency.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch in pixels
- H_SYNC, 96, horizontal sync width in pixels
- H_BACK, 48, horizontal back porch in pixels
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch in lines
- V_SYNC, 2, vertical sync width in lines
- V_BACK, 33, vertical back porch in lines
- SYNC_DELAY, 1, pixel ticks of delay applied to hs/vs/blank relative to DrawX/DrawY; legal range 0..4

Ports:
- Clk  input  1  50 MHz system clock; the only clock
- Reset  input  1  synchronous, active-high reset
- pixel_clk  output  1  25 MHz pixel clock: registered, toggles every Clk
- DrawX  output  10  horizontal counter hc, 0..799
- DrawY  output  10  vertical counter vc, 0..524
- hs  output  1  horizontal sync, active low, delayed SYNC_DELAY ticks
- vs  output  1  vertical sync, active low, delayed SYNC_DELAY ticks
- blank  output  1  1 = active display region (draw), 0 = blanking; delayed SYNC_DELAY ticks
- frame_start  output  1  one-Clk pulse when (hc,vc) wraps to (0,0)

Behaviour:
- Totals: HT = sum of H_*, 800 by default. VT = sum of V_*, 525 by default. All counter arithmetic is unsigned 10-bit.
- Reset (sampled on posedge Clk while Reset=1) sets:
  - phase=0, pixel_clk=0, hc=vc=0, frame_start=0
  - every delay stage to its inactive value (hs=1, vs=1, blank=0); the outputs show those values during reset
- Reset asserted mid-frame wins over every other update. The first tick after release is a fresh frame.
- Phase:
  - phase toggles every Clk when not in reset; pixel_clk = phase.
  - A pixel tick is a Clk cycle with phase==1, so counters update at the Clk edge where pixel_clk falls.
  - DrawX/DrawY are therefore stable across the pixel_clk rising edge.
- Horizontal counter: on a tick, hc = (hc==HT-1) ? 0 : hc+1.
- Vertical counter: on a tick with hc==HT-1, vc = (vc==VT-1) ? 0 : vc+1. Both wraps happen on the same tick.
- DrawX = hc and DrawY = vc, taken direct from the counter registers (zero latency).
- Undelayed sync terms, combinational from the current hc/vc:
  - hs_raw = 0 iff H_VISIBLE+H_FRONT <= hc < H_VISIBLE+H_FRONT+H_SYNC (656..751)
  - vs_raw = 0 iff V_VISIBLE+V_FRONT <= vc < V_VISIBLE+V_FRONT+V_SYNC (490..491)
  - blank_raw = 1 iff hc<H_VISIBLE and vc<V_VISIBLE
- Delay line:
  - A SYNC_DELAY-deep shift register carries {hs_raw, vs_raw, blank_raw} and advances only on ticks.
  - With SYNC_DELAY=0 the outputs are registered versions of the raw terms, updated at the same Clk edge as the counters. They then match the (hc,vc) that results from that edge, i.e. the raw terms are computed from the next-state counters.
  - With SYNC_DELAY=N the outputs correspond to the (hc,vc) that was current N ticks earlier.
- frame_start: set to 1 for exactly one Clk cycle, namely the cycle after the tick that wraps hc from HT-1 to 0 and vc from VT-1 to 0. It is 0 in every other cycle. It is not delayed.
- Timing invariants:
  - One line = HT ticks = 2*HT Clk cycles (1600 by default).
  - One frame = 2*HT*VT Clk cycles (840000 by default).
  - No skipped or duplicated counts.

Test Plan:
- Reset then release, SYNC_DELAY=1: at release hc=vc=0, pixel_clk=0, hs=vs=1, blank=0, frame_start=0. pixel_clk toggles every Clk. hc=1 after 2 Clk cycles and hc=N after 2N cycles.
- Horizontal sync, SYNC_DELAY=0: hs falls on the edge where DrawX becomes 656 and rises where DrawX becomes 752. Low width is 96 ticks = 192 Clk cycles. blank falls where DrawX becomes 640 and rises where DrawX returns to 0 on a visible line.
- Line and frame wrap: at (799,5) the next tick gives (0,6). At (799,524) the next tick gives (0,0), and frame_start pulses high for exactly one Clk. The interval between frame_start pulses is 840000 Clk cycles.
- Vertical sync: vs is low only while DrawY is 490 or 491 (adjusted by SYNC_DELAY). blank stays 0 for every DrawX while DrawY is 480..524.
- SYNC_DELAY=2 versus 0: run both with identical stimulus. The hs/vs/blank waveforms of the delayed run are the zero-delay waveforms shifted by exactly 2 ticks (4 Clk cycles). DrawX/DrawY are identical in both runs.
- Mid-frame reset: assert Reset for 3 Clk at (300,200). During reset hc=vc=0, hs=vs=1, blank=0. After release counting resumes from (0,0), with no frame_start pulse until the next full wrap.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel clock, DrawX/DrawY counters, delayed hs/vs/blank
// and a one-cycle frame_start pulse, all in the Clk domain.
module vga_timing_gen #(
   parameter int H_VISIBLE  = 640,
   parameter int H_FRONT    = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BACK     = 48,
   parameter int V_VISIBLE  = 480,
   parameter int V_FRONT    = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BACK     = 33,
   parameter int SYNC_DELAY = 1
) (
   input  logic       Clk,
   input  logic       Reset,
   output logic       pixel_clk,
   output logic [9:0] DrawX,
   output logic [9:0] DrawY,
   output logic       hs,
   output logic       vs,
   output logic       blank,
   output logic       frame_start
);

   localparam int HT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int VT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [9:0] H_LAST   = 10'(HT - 1);
   localparam logic [9:0] V_LAST   = 10'(VT - 1);
   localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
   localparam logic [9:0] HS_BEG   = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [9:0] VS_BEG   = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

   typedef struct packed {
      logic hs;
      logic vs;
      logic blank;
   } sync_t;

   localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, blank: 1'b0};

   logic       phase;
   logic [9:0] hc, vc;
   logic [9:0] hc_nx, vc_nx;
   logic       h_wrap, v_wrap;
   sync_t      sync_nx;

   // Stage 0 holds the sync terms of the current counters; each further
   // stage is one pixel tick older, so stage SYNC_DELAY drives the pins.
   sync_t [SYNC_DELAY:0] sync_pipe;

   // Counter next-state and the raw sync terms of that next state, so that
   // stage 0 lands in step with the counters on the same edge.
   always_comb begin
      h_wrap        = (hc == H_LAST);
      v_wrap        = (vc == V_LAST);
      hc_nx         = h_wrap ? 10'd0 : hc + 10'd1;
      vc_nx         = vc;
      if (h_wrap)
         vc_nx      = v_wrap ? 10'd0 : vc + 10'd1;
      sync_nx.hs    = !((hc_nx >= HS_BEG) && (hc_nx < HS_END));
      sync_nx.vs    = !((vc_nx >= VS_BEG) && (vc_nx < VS_END));
      sync_nx.blank = (hc_nx < H_VIS) && (vc_nx < V_VIS);
   end

   // Phase toggle, counters on pixel ticks (phase==1), sync delay line and
   // the frame wrap pulse; reset overrides everything.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         phase       <= 1'b0;
         hc          <= 10'd0;
         vc          <= 10'd0;
         frame_start <= 1'b0;
         for (int i = 0; i <= SYNC_DELAY; i++)
            sync_pipe[i] <= SYNC_IDLE;
      end else begin
         phase       <= ~phase;
         frame_start <= phase && h_wrap && v_wrap;
         if (phase) begin
            hc           <= hc_nx;
            vc           <= vc_nx;
            sync_pipe[0] <= sync_nx;
            for (int i = 1; i <= SYNC_DELAY; i++)
               sync_pipe[i] <= sync_pipe[i-1];
         end
      end
   end

   assign pixel_clk = phase;
   assign DrawX     = hc;
   assign DrawY     = vc;
   assign hs        = sync_pipe[SYNC_DELAY].hs;
   assign vs        = sync_pipe[SYNC_DELAY].vs;
   assign blank     = sync_pipe[SYNC_DELAY].blank;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (full VGA geometry with zero
// delay, plus a tiny geometry at delays 2 and 1) share Clk and a randomly
// pulsed Reset; every cycle each is compared against an arithmetic model
// derived from the number of Clk edges since the last reset release.
module tb_vga_timing_gen;

   logic Clk = 1'b0;
   logic Reset = 1'b1;

   logic [2:0]      pclk, hs, vs, blank, fs;
   logic [2:0][9:0] dx, dy;

   int c = 0;
   int n_pass = 0;
   int n_total = 0;
   int rst_left = 0;

   always #10 Clk = ~Clk;

   // Clk edges seen since reset was last released.
   always @(posedge Clk) c <= Reset ? 0 : c + 1;

   vga_timing_gen #(.SYNC_DELAY(0)) u_a (
      .Clk(Clk), .Reset(Reset), .pixel_clk(pclk[0]), .DrawX(dx[0]), .DrawY(dy[0]),
      .hs(hs[0]), .vs(vs[0]), .blank(blank[0]), .frame_start(fs[0]));

   vga_timing_gen #(.H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
                    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
                    .SYNC_DELAY(2)) u_b (
      .Clk(Clk), .Reset(Reset), .pixel_clk(pclk[1]), .DrawX(dx[1]), .DrawY(dy[1]),
      .hs(hs[1]), .vs(vs[1]), .blank(blank[1]), .frame_start(fs[1]));

   vga_timing_gen #(.H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
                    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
                    .SYNC_DELAY(1)) u_c (
      .Clk(Clk), .Reset(Reset), .pixel_clk(pclk[2]), .DrawX(dx[2]), .DrawY(dy[2]),
      .hs(hs[2]), .vs(vs[2]), .blank(blank[2]), .frame_start(fs[2]));

   // Expected {pixel_clk, DrawX, DrawY, hs, vs, blank, frame_start} after
   // ce Clk edges out of reset: k = ce/2 ticks have elapsed, the raster
   // position is k folded into the line/frame, and the sync pins show the
   // position d ticks back (idle until that position has actually been
   // reached after a tick).
   function automatic logic [24:0] model(int ce, int hv, int hf, int hsw, int hb,
                                         int vv, int vf, int vsw, int vb, int d);
      int ht = hv + hf + hsw + hb;
      int vt = vv + vf + vsw + vb;
      int k  = ce / 2;
      int p, ph, pv;
      logic h, v, bl, f;
      f  = (ce % 2 == 0) && (k > 0) && (k % (ht * vt) == 0);
      h  = 1'b1;
      v  = 1'b1;
      bl = 1'b0;
      if (k > d) begin
         p  = k - d;
         ph = p % ht;
         pv = (p / ht) % vt;
         h  = !(ph >= hv + hf && ph < hv + hf + hsw);
         v  = !(pv >= vv + vf && pv < vv + vf + vsw);
         bl = (ph < hv) && (pv < vv);
      end
      return {1'(ce % 2), 10'(k % ht), 10'((k / ht) % vt), h, v, bl, f};
   endfunction

   task automatic chk(input string tag, input logic [24:0] got, input logic [24:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s c=%0d got pc=%b x=%0d y=%0d hs/vs/bl/fs=%b expected pc=%b x=%0d y=%0d hs/vs/bl/fs=%b",
                    tag, c, got[24], got[23:14], got[13:4], got[3:0],
                    exp[24], exp[23:14], exp[13:4], exp[3:0]);
   endtask

   initial begin
      for (int i = 0; i < 20000; i++) begin
         @(negedge Clk);
         if (i >= 1) begin
            chk("vga_d0", {pclk[0], dx[0], dy[0], hs[0], vs[0], blank[0], fs[0]},
                model(c, 640, 16, 96, 48, 480, 10, 2, 33, 0));
            chk("tiny_d2", {pclk[1], dx[1], dy[1], hs[1], vs[1], blank[1], fs[1]},
                model(c, 8, 2, 3, 2, 6, 1, 2, 1, 2));
            chk("tiny_d1", {pclk[2], dx[2], dy[2], hs[2], vs[2], blank[2], fs[2]},
                model(c, 8, 2, 3, 2, 6, 1, 2, 1, 1));
         end
         // Long clean run first (covers full VGA lines), then a directed
         // 3-cycle mid-frame reset, then sporadic random-length resets.
         if (i == 6000) rst_left = 3;
         else if (i > 6000 && rst_left == 0 && $urandom_range(0, 599) == 0)
            rst_left = $urandom_range(1, 4);
         Reset = (i < 3) || (rst_left > 0);
         if (rst_left > 0) rst_left--;
      end
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
